nonrestoring_divider: RTL and testbench
=======================================

# nonrestoring_divider

Sequential unsigned 8-bit by 8-bit non-restoring divider. It is the inverse companion to the sequential Booth multiplier and uses the same one-clock, register-per-step style. It produces an 8-bit quotient and an 8-bit remainder through a start/busy/done handshake. It sits beside the multiplier in the FPGA build: dividend on SW7..SW0, divisor on SW15..SW8, `{quotient, remainder}` on LED15..LED0.

## Interface
Parameters:
- None. Widths are fixed: dividend and divisor 8 bits, partial remainder 9 bits.

Ports:
- `clk` input 1: system clock, 100 MHz. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. `rst`=0 forces the reset state immediately.
- `start` input 1: request a division. Sampled only in IDLE.
- `dividend` input 8: unsigned dividend. Latched on the accepted start edge.
- `divisor` input 8: unsigned divisor. Latched on the accepted start edge.
- `quotient` output 8: result quotient. Held until the next result write.
- `remainder` output 8: result remainder. Held until the next result write.
- `busy` output 1: high in RUN and FIX.
- `done` output 1: high for exactly one cycle, in DONE.
- `div_zero` output 1: set with a divide-by-zero result; cleared with the next result write.

## Operation
States:
- IDLE: waits for `start`.
- RUN: 8 iteration cycles.
- FIX: 1 remainder-correction cycle.
- DONE: 1 cycle with `done`=1.

Internal registers:
- A: 9-bit signed partial remainder.
- Q: 8-bit working quotient.
- M: 8-bit divisor.
- cnt: 4-bit iteration counter.

IDLE, `start`=1, `divisor`≠0:
- Load A=0, Q=`dividend`, M=`divisor`, cnt=0.
- Go to RUN.

IDLE, `start`=1, `divisor`=0:
- Write `quotient`=8'hFF, `remainder`=`dividend`, `div_zero`=1.
- Go straight to DONE. No iterations.

RUN, each cycle:
- Shift {A,Q} left by one bit.
- If the old A[8]=0, A=A−{0,M}; otherwise A=A+{0,M}.
- Set Q[0]=~A_new[8].
- Increment cnt.
- When cnt reaches 8 on this edge, go to FIX.

FIX:
- If A[8]=1, A=A+{0,M}.
- Write `quotient`=Q, `remainder`=A[7:0], `div_zero`=0.
- Go to DONE.

DONE:
- Unconditionally go to IDLE.

Boundary conditions:
- Invariant for every non-zero divisor: `quotient`·`divisor`+`remainder`=`dividend`, with `remainder`<`divisor`.
- `start` in RUN, FIX or DONE is ignored; a held `start` is re-accepted only after returning to IDLE.
- Operand changes after the accepting edge have no effect on the running division.
- `rst` low mid-operation aborts it: state IDLE, all registers and outputs 0, no `done` pulse.
- `start` high during reset is ignored; the first acceptance is the first rising edge with `rst`=1 and `start`=1.
- Arithmetic is unsigned on the inputs; only A uses 9-bit two's complement. No overflow is possible: quotient≤255.

## Timing
Reset values:
- `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE.

Normal divide, start accepted at edge k:
- `busy` is high from k to k+9.
- Edges k+1..k+8 perform the 8 iterations.
- Edge k+9 performs FIX and writes the outputs.
- `done` is high from k+9 to k+10; back in IDLE after k+10.
- Done latency is 9 cycles; the next start can be accepted at k+11.

Divide by zero, start accepted at edge k:
- Outputs written at k.
- `done` is high from k to k+1; `busy` stays 0.

Output stability:
- Results are valid, and never change, while `done`=1 and until the next write.

## Test plan
- Reset, then `dividend`=100, `divisor`=7, 1-cycle `start` -> `quotient`=14, `remainder`=2, `div_zero`=0. `done` pulses exactly once, 9 cycles after the start edge; `busy` is high for 9 cycles.
- 255/1 -> 255 r 0. 5/9 -> 0 r 5. 0/13 -> 0 r 0. 200/200 -> 1 r 0.
- 200/0 -> `quotient`=8'hFF, `remainder`=8'hC8, `div_zero`=1. `done` 1 cycle after start, `busy` never high. A following 10/3 gives 3 r 1 with `div_zero`=0.
- Start 100/7, pulse `start` with 50/5 in RUN cycle 4 -> the second start is ignored; result 14 r 2, single `done`.
- Start 100/7, drive `rst`=0 asynchronously at RUN cycle 5 -> all outputs 0 immediately, no `done`. After release, 77/8 -> 9 r 5.
- Exhaustive 65,280 non-zero-divisor pairs, back-to-back starts -> every result matches `/` and `%`, `done` once per accepted start.

Source files
------------

// File: rtl/nonrestoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// Master issues operands; slave returns quotient, remainder and status.
interface nonrestoring_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned 8/8 non-restoring divider, one step per clock.
// IDLE -> RUN (8 steps) -> FIX (remainder correction) -> DONE.
module nonrestoring_divider (
    input  logic                 clk,
    input  logic                 rst,
    nonrestoring_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [8:0] a_q;
    logic [7:0] q_q;
    logic [7:0] m_q;
    logic [3:0] cnt_q;
    logic [7:0] quot_q;
    logic [7:0] rem_q;
    logic       dz_q;

    logic       accept;
    logic       zero_div;
    logic [8:0] a_sh;
    logic [8:0] a_step;
    logic [7:0] q_step;
    logic [8:0] a_corr;

    assign accept   = (state_q == IDLE) && bus.start;
    assign zero_div = (bus.divisor == 8'd0);

    // One non-restoring step: shift {A,Q}, then add or subtract M by old sign.
    always_comb begin
        a_sh   = {a_q[7:0], q_q[7]};
        a_step = a_q[8] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
        q_step = {q_q[6:0], ~a_step[8]};
        a_corr = a_q[8] ? (a_q + {1'b0, m_q}) : a_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; the 8th step is the one taken while cnt is 7.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = zero_div ? DONE : RUN;
            end
            RUN: begin
                if (cnt_q == 4'd7) state_d = FIX;
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result registers; results only change on a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && zero_div) begin
                        quot_q <= 8'hFF;
                        rem_q  <= bus.dividend;
                        dz_q   <= 1'b1;
                    end else if (accept) begin
                        a_q   <= '0;
                        q_q   <= bus.dividend;
                        m_q   <= bus.divisor;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q + 4'd1;
                end
                FIX: begin
                    a_q    <= a_corr;
                    quot_q <= q_q;
                    rem_q  <= a_corr[7:0];
                    dz_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.busy      = (state_q == RUN) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider: vector table plus
// hand-written sequences for ignored start, abort and a wide sweep.
module tb_nonrestoring_divider;

    logic clk;
    logic rst;

    nonrestoring_divider_if bus ();

    nonrestoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd;
        logic [7:0] dv;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
        int         nb;
    } vec_t;

    vec_t tbl[7];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Issue one start, then sample each negedge until done (bounded).
    // Sample i=0 is the first negedge after the accepting edge.
    task automatic run_div(input logic [7:0] dd, input logic [7:0] dv,
                           output int lat, output int nb);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(negedge clk);
        bus.start    = 1'b0;
        lat = -1;
        nb  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    int lat;
    int nb;
    int ndone;
    string nm;

    initial begin
        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 9};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 9};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 9};
        tbl[3] = '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0, 9, 9};
        tbl[4] = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 9, 9};
        tbl[5] = '{8'd200, 8'd0,   8'hFF,  8'hC8,  1'b1, 0, 0};
        tbl[6] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9, 9};

        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        repeat (3) @(negedge clk);

        check("reset_quotient",  int'(bus.quotient),  0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_busy",      int'(bus.busy),      0);
        check("reset_done",      int'(bus.done),      0);
        check("reset_div_zero",  int'(bus.div_zero),  0);
        rst = 1'b1;

        // Table-driven vectors, back-to-back.
        for (int i = 0; i < 7; i++) begin
            run_div(tbl[i].dd, tbl[i].dv, lat, nb);
            $sformat(nm, "vec%0d", i);
            check({nm, "_quotient"},  int'(bus.quotient),  int'(tbl[i].q));
            check({nm, "_remainder"}, int'(bus.remainder), int'(tbl[i].r));
            check({nm, "_div_zero"},  int'(bus.div_zero),  int'(tbl[i].dz));
            check({nm, "_latency"},   lat, tbl[i].lat);
            check({nm, "_busy_cyc"},  nb,  tbl[i].nb);
        end

        // done must be a single-cycle pulse.
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);

        // Second start in RUN with new operands is ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int i = 0; i < 24; i++) begin
            if (i == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            @(negedge clk);
        end
        check("ign_done_count", ndone, 1);
        check("ign_latency",    lat,   9);
        check("ign_quotient",   int'(bus.quotient),  14);
        check("ign_remainder",  int'(bus.remainder), 2);

        // Asynchronous reset in the middle of RUN aborts the division.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_quotient",  int'(bus.quotient),  0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_busy",      int'(bus.busy),      0);
        check("abort_done",      int'(bus.done),      0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_div(8'd77, 8'd8, lat, nb);
        check("post_abort_quotient",  int'(bus.quotient),  9);
        check("post_abort_remainder", int'(bus.remainder), 5);
        check("post_abort_latency",   lat, 9);

        // Sweep all dividends against a spread of divisors.
        for (int d = 0; d < 10; d++) begin
            logic [7:0] dvs [10];
            dvs = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd13,
                    8'd64, 8'd127, 8'd128, 8'd200, 8'd255};
            for (int x = 0; x < 256; x++) begin
                run_div(x[7:0], dvs[d], lat, nb);
                $sformat(nm, "sweep_%0d_%0d", x, dvs[d]);
                check({nm, "_q"},   int'(bus.quotient),  x / int'(dvs[d]));
                check({nm, "_r"},   int'(bus.remainder), x % int'(dvs[d]));
                check({nm, "_lat"}, lat, 9);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
